// File: rtl/alu_op_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode, owner and FSM state definitions for the
//                ALU pass scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode width seen by ALU_Control
    localparam int ALU_OP_W = 4;

    // Opcode 0 means "no ALU pass"; it still occupies one scheduling beat
    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'd0;

    // Requester identity carried with every operation
    localparam logic OWNER_PIPE = 1'b0;
    localparam logic OWNER_AUX  = 1'b1;

    // Scheduler FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_scheduler_if
//  Description : Request/ALU bundle between the requesters (master side) and
//                the ALU pass scheduler (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_scheduler_if #(
    parameter int BEAT_W = 2
);
    import alu_pkg::*;

    // Requester side
    logic                Flush;
    logic                PipeValid;
    logic                PipeReady;
    logic [ALU_OP_W-1:0] PipeOp;
    logic [BEAT_W-1:0]   PipeBeats;
    logic                AuxValid;
    logic                AuxReady;
    logic [ALU_OP_W-1:0] AuxOp;
    logic [BEAT_W-1:0]   AuxBeats;

    // ALU_Control side
    logic [ALU_OP_W-1:0] AluOp;
    logic                AluActive;
    logic                AluFirst;
    logic                AluLast;
    logic [BEAT_W-1:0]   AluBeat;
    logic                AluOwner;
    logic                ResultValid;
    logic                ResultOwner;
    logic                Busy;

    modport master (
        output Flush, PipeValid, PipeOp, PipeBeats, AuxValid, AuxOp, AuxBeats,
        input  PipeReady, AuxReady,
        input  AluOp, AluActive, AluFirst, AluLast, AluBeat, AluOwner,
        input  ResultValid, ResultOwner, Busy
    );

    modport slave (
        input  Flush, PipeValid, PipeOp, PipeBeats, AuxValid, AuxOp, AuxBeats,
        output PipeReady, AuxReady,
        output AluOp, AluActive, AluFirst, AluLast, AluBeat, AluOwner,
        output ResultValid, ResultOwner, Busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Pipe-priority arbiter with an Aux starvation guard. Produces
//                the combinational ready/grant and tracks how many Pipe
//                grants in a row were taken while Aux was waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_slot_open,
    input  wire logic i_flush,
    input  wire logic i_pipe_valid,
    input  wire logic i_aux_valid,
    output logic      o_pipe_ready,
    output logic      o_aux_ready,
    output logic      o_grant,
    output logic      o_grant_owner
);

    localparam logic [2:0] C_LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_q;
    logic [2:0] starve_d;
    logic       w_pipe_elig;
    logic       w_aux_win;
    logic       w_pipe_win;

    // Winner select, ready generation and starvation-count update
    always_comb begin
        // A flushed Pipe request is not a contender, so Aux can take the slot
        w_pipe_elig   = i_pipe_valid & ~i_flush;
        w_aux_win     = i_aux_valid & (~w_pipe_elig | (starve_q == C_LIMIT));
        w_pipe_win    = w_pipe_elig & ~w_aux_win;
        o_pipe_ready  = i_slot_open & w_pipe_win;
        o_aux_ready   = i_slot_open & w_aux_win;
        o_grant       = o_pipe_ready | o_aux_ready;
        o_grant_owner = w_aux_win ? OWNER_AUX : OWNER_PIPE;

        starve_d = starve_q;
        if (o_aux_ready) begin
            starve_d = 3'd0;
        end else if (o_pipe_ready) begin
            if (!i_aux_valid) begin
                starve_d = 3'd0;
            end else if (starve_q != C_LIMIT) begin
                starve_d = starve_q + 3'd1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_scheduler
//  Description : Holds the ALU for 1..2^BEAT_W chained passes per operation,
//                arbitrates Pipe/Aux requests, honours pipeline flush and
//                reports per-owner completion one cycle after the last beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int BEAT_W       = 2
) (
    input  wire logic         Clock,
    input  wire logic         Reset_n,
    alu_op_scheduler_if.slave bus
);

    sched_state_e        state_q, state_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [BEAT_W-1:0]   last_idx_q, last_idx_d;
    logic                owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                active_q, active_d;
    logic                result_valid_q, result_valid_d;
    logic                result_owner_q, result_owner_d;

    logic                w_slot_open;
    logic                w_pipe_ready;
    logic                w_aux_ready;
    logic                w_grant;
    logic                w_grant_owner;
    logic [ALU_OP_W-1:0] w_win_op;
    logic [BEAT_W-1:0]   w_win_beats;
    logic                w_ending;
    logic                w_kill;
    logic [BEAT_W-1:0]   w_beat_nxt;

    // A new operation may start when idle or on the final beat of the current one
    assign w_slot_open = Reset_n & ((state_q == IDLE) | ((state_q == RUN) & last_q));

    alu_req_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .i_clk         (Clock),
        .i_rst_n       (Reset_n),
        .i_slot_open   (w_slot_open),
        .i_flush       (bus.Flush),
        .i_pipe_valid  (bus.PipeValid),
        .i_aux_valid   (bus.AuxValid),
        .o_pipe_ready  (w_pipe_ready),
        .o_aux_ready   (w_aux_ready),
        .o_grant       (w_grant),
        .o_grant_owner (w_grant_owner)
    );

    assign w_win_op    = (w_grant_owner == OWNER_AUX) ? bus.AuxOp    : bus.PipeOp;
    assign w_win_beats = (w_grant_owner == OWNER_AUX) ? bus.AuxBeats : bus.PipeBeats;
    assign w_ending    = (state_q == RUN) & last_q;
    assign w_kill      = (state_q == RUN) & (owner_q == OWNER_PIPE) & bus.Flush;
    assign w_beat_nxt  = beat_q + BEAT_W'(1);

    // Next-state: load a granted op, advance the beat, or drop back to idle
    always_comb begin
        state_d    = IDLE;
        op_d       = ALU_NOP;
        last_idx_d = '0;
        owner_d    = OWNER_PIPE;
        beat_d     = '0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        active_d   = 1'b0;

        // A flushed Pipe op never reports completion, even on its last beat
        result_valid_d = w_ending & ~w_kill;
        result_owner_d = result_valid_d & owner_q;

        if (w_grant) begin
            state_d    = RUN;
            op_d       = w_win_op;
            owner_d    = w_grant_owner;
            first_d    = 1'b1;
            active_d   = (w_win_op != ALU_NOP);
            // NOP always takes a single beat whatever its beat count says
            last_idx_d = (w_win_op == ALU_NOP) ? '0 : w_win_beats;
            last_d     = (w_win_op == ALU_NOP) | (w_win_beats == '0);
        end else if ((state_q == RUN) && !last_q && !w_kill) begin
            state_d    = RUN;
            op_d       = op_q;
            last_idx_d = last_idx_q;
            owner_d    = owner_q;
            beat_d     = w_beat_nxt;
            first_d    = 1'b0;
            last_d     = (w_beat_nxt == last_idx_q);
            active_d   = active_q;
        end
    end

    // State and registered ALU-side outputs
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            op_q           <= ALU_NOP;
            last_idx_q     <= '0;
            owner_q        <= OWNER_PIPE;
            beat_q         <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            active_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_owner_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            last_idx_q     <= last_idx_d;
            owner_q        <= owner_d;
            beat_q         <= beat_d;
            first_q        <= first_d;
            last_q         <= last_d;
            active_q       <= active_d;
            result_valid_q <= result_valid_d;
            result_owner_q <= result_owner_d;
        end
    end

    assign bus.PipeReady   = w_pipe_ready;
    assign bus.AuxReady    = w_aux_ready;
    assign bus.AluOp       = op_q;
    assign bus.AluActive   = active_q;
    assign bus.AluFirst    = first_q;
    assign bus.AluLast     = last_q;
    assign bus.AluBeat     = beat_q;
    assign bus.AluOwner    = owner_q;
    assign bus.ResultValid = result_valid_q;
    assign bus.ResultOwner = result_owner_q;
    assign bus.Busy        = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_scheduler
//  Description : Directed scenarios plus randomized traffic against a
//                transaction-level model of the ALU pass scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;
    import alu_pkg::*;

    localparam int BW = 2;
    localparam int SL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_op_scheduler_if #(.BEAT_W(BW)) bus ();

    alu_op_scheduler #(
        .STARVE_LIMIT (SL),
        .BEAT_W       (BW)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [3:0] pop, input logic [BW-1:0] pb,
                         input logic av, input logic [3:0] aop, input logic [BW-1:0] ab,
                         input logic fl);
        bus.PipeValid = pv;
        bus.PipeOp    = pop;
        bus.PipeBeats = pb;
        bus.AuxValid  = av;
        bus.AuxOp     = aop;
        bus.AuxBeats  = ab;
        bus.Flush     = fl;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0);
    endtask

    // Advance to the next cycle's drive point
    task automatic nc();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Transaction-level model: the operation in flight is a descriptor
    // (owner, opcode, total beats, current beat); outputs follow from it.
    // ---------------------------------------------------------------------
    bit m_busy   = 0;
    bit m_owner  = 0;
    int m_op     = 0;
    int m_total  = 0;
    int m_idx    = 0;
    int m_starve = 0;
    bit m_rv     = 0;
    bit m_rown   = 0;

    initial begin : compare
        bit slot, pe, aw, pw, ending, killed;
        int nb;
        forever begin
            @(negedge clk);
            #1;
            slot = (rst_n === 1'b1) && (!m_busy || (m_idx == m_total - 1));
            pe   = bus.PipeValid && !bus.Flush;
            aw   = bus.AuxValid && (!pe || (m_starve == SL));
            pw   = pe && !aw;

            chk("m_PipeReady", bus.PipeReady, slot && pw);
            chk("m_AuxReady", bus.AuxReady, slot && aw);
            chk("m_Busy", bus.Busy, m_busy);
            chk("m_AluActive", bus.AluActive, m_busy && (m_op != 0));
            chk("m_ResultValid", bus.ResultValid, m_rv);
            if (m_rv) chk("m_ResultOwner", bus.ResultOwner, m_rown);
            if (m_busy) begin
                chk("m_AluOp", bus.AluOp, m_op);
                chk("m_AluFirst", bus.AluFirst, m_idx == 0);
                chk("m_AluLast", bus.AluLast, m_idx == m_total - 1);
                chk("m_AluBeat", bus.AluBeat, m_idx);
                chk("m_AluOwner", bus.AluOwner, m_owner);
            end

            // Advance the model across the coming rising edge
            if (rst_n !== 1'b1) begin
                m_busy = 0; m_owner = 0; m_op = 0; m_total = 0; m_idx = 0;
                m_starve = 0; m_rv = 0; m_rown = 0;
            end else begin
                ending = m_busy && (m_idx == m_total - 1);
                killed = m_busy && (m_owner == 0) && bus.Flush;
                m_rv   = ending && !killed;
                m_rown = m_owner;
                if (slot && (pw || aw)) begin
                    if (aw)                m_starve = 0;
                    else if (bus.AuxValid) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                    else                   m_starve = 0;
                    m_busy  = 1;
                    m_owner = aw;
                    m_op    = aw ? int'(bus.AuxOp) : int'(bus.PipeOp);
                    nb      = aw ? int'(bus.AuxBeats) : int'(bus.PipeBeats);
                    m_total = (m_op == 0) ? 1 : nb + 1;
                    m_idx   = 0;
                end else if (m_busy && !ending && !killed) begin
                    m_idx++;
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // ---------------------------------------------------------------------
    initial begin : stim
        bit exp_aux [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        drive(1'b1, 4'd3, '0, 1'b1, 4'd2, '0, 1'b0);
        rst_n = 1'b0;
        repeat (3) nc();
        #2;
        chk("rst_PipeReady", bus.PipeReady, 0);
        chk("rst_AuxReady", bus.AuxReady, 0);
        chk("rst_Busy", bus.Busy, 0);
        chk("rst_AluOp", bus.AluOp, 0);
        chk("rst_AluActive", bus.AluActive, 0);
        chk("rst_ResultValid", bus.ResultValid, 0);
        nc(); rst_n = 1'b1; idle_in();
        nc();

        // Single-beat Pipe op
        nc(); drive(1'b1, 4'd3, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0);
        #2 chk("t1_PipeReady", bus.PipeReady, 1);
        nc(); idle_in();
        #2 chk("t1_AluOp", bus.AluOp, 3);
        chk("t1_AluActive", bus.AluActive, 1);
        chk("t1_AluFirst", bus.AluFirst, 1);
        chk("t1_AluLast", bus.AluLast, 1);
        nc();
        #2 chk("t1_ResultValid", bus.ResultValid, 1);
        chk("t1_ResultOwner", bus.ResultOwner, 0);
        nc();

        // Four-beat op followed back-to-back by a single-beat op
        nc(); drive(1'b1, 4'd5, 2'd3, 1'b0, 4'd0, 2'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            nc(); drive(1'b1, 4'd6, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0);
            #2 chk("t2_AluBeat", bus.AluBeat, c - 1);
            chk("t2_AluOp", bus.AluOp, 5);
            chk("t2_PipeReady", bus.PipeReady, (c == 4));
        end
        nc(); idle_in();
        #2 chk("t2_next_AluOp", bus.AluOp, 6);
        chk("t2_next_AluFirst", bus.AluFirst, 1);
        chk("t2_ResultValid_a", bus.ResultValid, 1);
        nc();
        #2 chk("t2_ResultValid_b", bus.ResultValid, 1);
        nc();

        // Starvation guard grant pattern
        for (int i = 0; i < 10; i++) begin
            nc(); drive(1'b1, 4'd1, 2'd0, 1'b1, 4'd2, 2'd0, 1'b0);
            #2 chk("t3_grant", {bus.PipeReady, bus.AuxReady}, exp_aux[i] ? 2'b01 : 2'b10);
        end
        nc(); idle_in();
        nc(); nc();

        // Flush mid Pipe op, then Aux op runs through flushes
        nc(); drive(1'b1, 4'd7, 2'd3, 1'b0, 4'd0, 2'd0, 1'b0);
        #2 chk("t4_PipeReady", bus.PipeReady, 1);
        nc(); idle_in();
        #2 chk("t4_beat0", bus.AluBeat, 0);
        nc(); drive(1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 2'd1, 1'b1);
        nc(); drive(1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 2'd1, 1'b0);
        #2 chk("t4_Busy", bus.Busy, 0);
        chk("t4_AluActive", bus.AluActive, 0);
        chk("t4_ResultValid", bus.ResultValid, 0);
        chk("t4_AuxReady", bus.AuxReady, 1);
        nc(); drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1);
        #2 chk("t5_AluOwner", bus.AluOwner, 1);
        chk("t5_AluOp", bus.AluOp, 2);
        nc();
        #2 chk("t5_AluLast", bus.AluLast, 1);
        nc(); idle_in();
        #2 chk("t5_ResultValid", bus.ResultValid, 1);
        chk("t5_ResultOwner", bus.ResultOwner, 1);
        nc();

        // NOP with a beat count of four takes one inactive beat
        nc(); drive(1'b1, 4'd0, 2'd3, 1'b0, 4'd0, 2'd0, 1'b0);
        nc(); idle_in();
        #2 chk("t6_Busy", bus.Busy, 1);
        chk("t6_AluActive", bus.AluActive, 0);
        chk("t6_AluLast", bus.AluLast, 1);
        nc();
        #2 chk("t6_ResultValid", bus.ResultValid, 1);
        chk("t6_Busy_after", bus.Busy, 0);
        nc();

        // Flush on a Pipe last beat: result dropped, Aux takes the slot
        nc(); drive(1'b1, 4'd8, 2'd1, 1'b0, 4'd0, 2'd0, 1'b0);
        nc(); idle_in();
        nc(); drive(1'b1, 4'd4, 2'd0, 1'b1, 4'd9, 2'd0, 1'b1);
        #2 chk("t7_AluLast", bus.AluLast, 1);
        chk("t7_PipeReady", bus.PipeReady, 0);
        chk("t7_AuxReady", bus.AuxReady, 1);
        nc(); idle_in();
        #2 chk("t7_ResultValid", bus.ResultValid, 0);
        chk("t7_AluOp", bus.AluOp, 9);
        nc();
        #2 chk("t7_ResultOwner", bus.ResultOwner, 1);
        nc();

        // Reset in the middle of an operation
        nc(); drive(1'b1, 4'd5, 2'd3, 1'b0, 4'd0, 2'd0, 1'b0);
        nc(); idle_in();
        nc(); rst_n = 1'b0; drive(1'b1, 4'd1, 2'd0, 1'b1, 4'd1, 2'd0, 1'b0);
        #2 chk("t8_PipeReady", bus.PipeReady, 0);
        chk("t8_AuxReady", bus.AuxReady, 0);
        nc(); rst_n = 1'b1; idle_in();
        #2 chk("t8_Busy", bus.Busy, 0);
        chk("t8_AluOp", bus.AluOp, 0);
        chk("t8_AluBeat", bus.AluBeat, 0);
        chk("t8_AluFirst", bus.AluFirst, 0);
        chk("t8_ResultValid", bus.ResultValid, 0);
        nc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nc();
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.PipeValid = ($urandom_range(0, 9) < 6);
            bus.AuxValid  = ($urandom_range(0, 9) < 4);
            bus.Flush     = ($urandom_range(0, 9) == 0);
            bus.PipeOp    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            bus.AuxOp     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            bus.PipeBeats = ($urandom_range(0, 1) == 1) ? BW'(0) : BW'($urandom);
            bus.AuxBeats  = ($urandom_range(0, 1) == 1) ? BW'(0) : BW'($urandom);
        end
        nc(); rst_n = 1'b1; idle_in();
        repeat (6) nc();
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
